// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester, RAM and response signals of the two-port memory arbiter
interface mem_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic          i_req0, i_req1;
  logic          i_we0, i_we1;
  logic [AW-1:0] i_addr0, i_addr1;
  logic [DW-1:0] i_wdata0, i_wdata1;
  logic          o_gnt0, o_gnt1;
  logic          o_rvalid0, o_rvalid1;
  logic [DW-1:0] o_rdata0, o_rdata1;
  logic          o_mem_en, o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic [DW-1:0] i_mem_rdata;
  logic          o_busy;

  modport slave (
    input  i_req0, i_req1, i_we0, i_we1, i_addr0, i_addr1, i_wdata0, i_wdata1, i_mem_rdata,
    output o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_rdata0, o_rdata1,
    output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_busy
  );

  modport master (
    output i_req0, i_req1, i_we0, i_we1, i_addr0, i_addr1, i_wdata0, i_wdata1, i_mem_rdata,
    input  o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_rdata0, o_rdata1,
    input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port single-RAM arbiter with registered command and fixed read latency
// MEM_ARB_FIXED_PRIO_EN: port 0 always wins ties (no last-served pointer); default is round-robin.
module mem_arbiter #(
  parameter int AW     = 10,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_e;

  localparam logic [1:0] CNT_INIT = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  state_e        state_q;
  logic [1:0]    cnt_q;
  logic          owner_q;
  logic          cmd_we_q;
  logic [AW-1:0] cmd_addr_q;
  logic [DW-1:0] cmd_wdata_q;
  logic          gnt0_q, gnt1_q;
  logic          rvalid0_q, rvalid1_q;
  logic [DW-1:0] rdata0_q, rdata1_q;
  logic          mem_en_q, mem_we_q;
  logic          busy_q;
  logic          pick1_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
  logic          last_q;
`endif

  // On a tie the port that was not served last wins.
  always_comb begin
    pick1_d = 1'b0;
    if (bus.i_req1 && !bus.i_req0) begin
      pick1_d = 1'b1;
    end
`ifndef MEM_ARB_FIXED_PRIO_EN
    else if (bus.i_req1 && bus.i_req0) begin
      pick1_d = !last_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      owner_q     <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      last_q      <= 1'b1;
`endif
    end else begin
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      mem_en_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.i_req0 || bus.i_req1) begin
            owner_q     <= pick1_d;
            cmd_we_q    <= pick1_d ? bus.i_we1 : bus.i_we0;
            cmd_addr_q  <= pick1_d ? bus.i_addr1 : bus.i_addr0;
            cmd_wdata_q <= pick1_d ? bus.i_wdata1 : bus.i_wdata0;
            mem_en_q    <= 1'b1;
            mem_we_q    <= pick1_d ? bus.i_we1 : bus.i_we0;
            gnt0_q      <= !pick1_d;
            gnt1_q      <= pick1_d;
            busy_q      <= 1'b1;
            state_q     <= ACCESS;
          end
        end
        ACCESS: begin
`ifndef MEM_ARB_FIXED_PRIO_EN
          last_q <= owner_q;
`endif
          if (cmd_we_q) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (RD_LAT == 1) begin
            state_q <= RESP;
          end else begin
            cnt_q   <= CNT_INIT;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == 2'd0) begin
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        RESP: begin
          if (owner_q) begin
            rdata1_q  <= bus.i_mem_rdata;
            rvalid1_q <= 1'b1;
          end else begin
            rdata0_q  <= bus.i_mem_rdata;
            rvalid0_q <= 1'b1;
          end
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_gnt0      = gnt0_q;
  assign bus.o_gnt1      = gnt1_q;
  assign bus.o_rvalid0   = rvalid0_q;
  assign bus.o_rvalid1   = rvalid1_q;
  assign bus.o_rdata0    = rdata0_q;
  assign bus.o_rdata1    = rdata1_q;
  assign bus.o_mem_en    = mem_en_q;
  assign bus.o_mem_we    = mem_we_q;
  assign bus.o_mem_addr  = cmd_addr_q;
  assign bus.o_mem_wdata = cmd_wdata_q;
  assign bus.o_busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed bench for mem_arbiter with RD_LAT=3 and RD_LAT=1 instances
module tb_mem_arbiter;

  logic clk;
  logic rst;

  mem_arbiter_if #(.AW(10), .DW(32)) bus_a ();
  mem_arbiter_if #(.AW(10), .DW(32)) bus_b ();

  mem_arbiter #(.AW(10), .DW(32), .RD_LAT(3)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  mem_arbiter #(.AW(10), .DW(32), .RD_LAT(1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

`ifdef MEM_ARB_FIXED_PRIO_EN
  localparam logic [3:0] EXP_SEQ = 4'b0000;
  localparam int         EXP_RV0 = 4;
  localparam int         EXP_RV1 = 0;
`else
  localparam logic [3:0] EXP_SEQ = 4'b1010;
  localparam int         EXP_RV0 = 2;
  localparam int         EXP_RV1 = 2;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM models: non-read cycles push a poison word so a mistimed capture is visible.
  logic [31:0] ram_a [0:1023];
  logic [31:0] pipe_a [0:2];
  logic [31:0] ram_b [0:1023];
  logic [31:0] pipe_b;

  always @(posedge clk) begin
    if (bus_a.o_mem_en && bus_a.o_mem_we) ram_a[bus_a.o_mem_addr] <= bus_a.o_mem_wdata;
    pipe_a[0] <= (bus_a.o_mem_en && !bus_a.o_mem_we) ? ram_a[bus_a.o_mem_addr] : 32'hBAD0_0000;
    pipe_a[1] <= pipe_a[0];
    pipe_a[2] <= pipe_a[1];
    if (bus_b.o_mem_en && bus_b.o_mem_we) ram_b[bus_b.o_mem_addr] <= bus_b.o_mem_wdata;
    pipe_b <= (bus_b.o_mem_en && !bus_b.o_mem_we) ? ram_b[bus_b.o_mem_addr] : 32'hBAD0_0001;
  end

  assign bus_a.i_mem_rdata = pipe_a[2];
  assign bus_b.i_mem_rdata = pipe_b;

  int          n_checks = 0;
  int          n_errors = 0;
  int          ngnt, nrv0, nrv1, cyc, tail;
  logic        prev_en;
  logic [3:0]  seq;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus_a.i_req0 = 1'b0; bus_a.i_req1 = 1'b0; bus_a.i_we0 = 1'b0; bus_a.i_we1 = 1'b0;
    bus_a.i_addr0 = '0; bus_a.i_addr1 = '0; bus_a.i_wdata0 = '0; bus_a.i_wdata1 = '0;
    bus_b.i_req0 = 1'b0; bus_b.i_req1 = 1'b0; bus_b.i_we0 = 1'b0; bus_b.i_we1 = 1'b0;
    bus_b.i_addr0 = '0; bus_b.i_addr1 = '0; bus_b.i_wdata0 = '0; bus_b.i_wdata1 = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);

    check("rst_flags_a", 64'({bus_a.o_gnt0, bus_a.o_gnt1, bus_a.o_rvalid0, bus_a.o_rvalid1,
                              bus_a.o_mem_en, bus_a.o_mem_we, bus_a.o_busy}), 64'(0));
    check("rst_rdata_a", 64'({bus_a.o_rdata0, bus_a.o_rdata1}), 64'(0));
    check("rst_busy_b", 64'(bus_b.o_busy), 64'(0));
    rst = 1'b0;

    // Single write on both instances: port 0, 0x004 <- 0xDEADBEEF
    bus_a.i_req0 = 1'b1; bus_a.i_we0 = 1'b1; bus_a.i_addr0 = 10'h004; bus_a.i_wdata0 = 32'hDEADBEEF;
    bus_b.i_req0 = 1'b1; bus_b.i_we0 = 1'b1; bus_b.i_addr0 = 10'h004; bus_b.i_wdata0 = 32'hDEADBEEF;
    @(negedge clk);
    check("wr_gnt0", 64'(bus_a.o_gnt0), 64'(1));
    check("wr_gnt1", 64'(bus_a.o_gnt1), 64'(0));
    check("wr_mem_en_we", 64'({bus_a.o_mem_en, bus_a.o_mem_we}), 64'(2'b11));
    check("wr_mem_addr", 64'(bus_a.o_mem_addr), 64'(10'h004));
    check("wr_mem_wdata", 64'(bus_a.o_mem_wdata), 64'(32'hDEADBEEF));
    check("wr_busy", 64'(bus_a.o_busy), 64'(1));
    check("wr_gnt0_b", 64'(bus_b.o_gnt0), 64'(1));
    bus_a.i_req0 = 1'b0; bus_a.i_we0 = 1'b0;
    bus_b.i_req0 = 1'b0; bus_b.i_we0 = 1'b0;
    @(negedge clk);
    check("wr_done_busy", 64'(bus_a.o_busy), 64'(0));
    check("wr_done_en", 64'(bus_a.o_mem_en), 64'(0));
    check("wr_done_busy_b", 64'(bus_b.o_busy), 64'(0));
    check("wr_ram", 64'(ram_a[4]), 64'(32'hDEADBEEF));

    // Read latency sweep: port 1 reads 0x004; RD_LAT=1 valid at I+3, RD_LAT=3 at I+5
    bus_a.i_req1 = 1'b1; bus_a.i_we1 = 1'b0; bus_a.i_addr1 = 10'h004;
    bus_b.i_req1 = 1'b1; bus_b.i_we1 = 1'b0; bus_b.i_addr1 = 10'h004;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("rd_gnt1_a", 64'(bus_a.o_gnt1), 64'(1));
        check("rd_gnt1_b", 64'(bus_b.o_gnt1), 64'(1));
        bus_a.i_req1 = 1'b0;
        bus_b.i_req1 = 1'b0;
      end
      check($sformatf("rd_rvalid1_a_k%0d", k), 64'(bus_a.o_rvalid1), 64'(k == 5));
      check($sformatf("rd_rvalid1_b_k%0d", k), 64'(bus_b.o_rvalid1), 64'(k == 3));
      check($sformatf("rd_rvalid0_k%0d", k), 64'(bus_a.o_rvalid0 | bus_b.o_rvalid0), 64'(0));
      if (k == 3) check("rd_rdata1_b", 64'(bus_b.o_rdata1), 64'(32'hDEADBEEF));
      if (k == 5) check("rd_rdata1_a", 64'(bus_a.o_rdata1), 64'(32'hDEADBEEF));
    end

    // Contention: both ports read continuously for four grants
    bus_a.i_req0 = 1'b1; bus_a.i_we0 = 1'b0; bus_a.i_addr0 = 10'h004;
    bus_a.i_req1 = 1'b1; bus_a.i_we1 = 1'b0; bus_a.i_addr1 = 10'h004;
    ngnt = 0; nrv0 = 0; nrv1 = 0; cyc = 0; tail = 0; prev_en = 1'b0; seq = 4'b0;
    while (cyc < 60 && tail < 6) begin
      @(negedge clk);
      cyc++;
      if (bus_a.o_mem_en) check("mem_en_gap", 64'(prev_en), 64'(0));
      prev_en = bus_a.o_mem_en;
      if (bus_a.o_rvalid0) nrv0++;
      if (bus_a.o_rvalid1) nrv1++;
      if (ngnt >= 4) tail++;
      if (bus_a.o_gnt0 || bus_a.o_gnt1) begin
        if (ngnt < 4) seq[ngnt] = bus_a.o_gnt1;
        ngnt++;
        if (ngnt == 4) begin
          bus_a.i_req0 = 1'b0;
          bus_a.i_req1 = 1'b0;
        end
      end
    end
    check("cont_grants", 64'(ngnt), 64'(4));
    check("cont_order", 64'(seq), 64'(EXP_SEQ));
    check("cont_rvalid0", 64'(nrv0), 64'(EXP_RV0));
    check("cont_rvalid1", 64'(nrv1), 64'(EXP_RV1));
    check("cont_rdata0", 64'(bus_a.o_rdata0), 64'(32'hDEADBEEF));
    check("cont_idle", 64'(bus_a.o_busy), 64'(0));

    // Late request: port 1 raises req while port 0's read is in WAIT
    bus_a.i_req0 = 1'b1; bus_a.i_we0 = 1'b0; bus_a.i_addr0 = 10'h004;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("late_gnt0", 64'(bus_a.o_gnt0), 64'(1));
        bus_a.i_req0 = 1'b0;
      end
      if (k == 2) begin
        bus_a.i_req1 = 1'b1; bus_a.i_we1 = 1'b0; bus_a.i_addr1 = 10'h004;
      end
      check($sformatf("late_rvalid0_k%0d", k), 64'(bus_a.o_rvalid0), 64'(k == 5));
      check($sformatf("late_gnt1_k%0d", k), 64'(bus_a.o_gnt1), 64'(k == 6));
      check($sformatf("late_rvalid1_k%0d", k), 64'(bus_a.o_rvalid1), 64'(k == 10));
      if (k == 6) begin
        check("late_mem_en", 64'(bus_a.o_mem_en), 64'(1));
        bus_a.i_req1 = 1'b0;
      end
    end

    // Reset mid-read: port 0 read, reset while in WAIT
    bus_a.i_req0 = 1'b1; bus_a.i_we0 = 1'b0; bus_a.i_addr0 = 10'h004;
    @(negedge clk);
    check("rstmid_gnt0", 64'(bus_a.o_gnt0), 64'(1));
    bus_a.i_req0 = 1'b0;
    @(negedge clk);
    check("rstmid_busy", 64'(bus_a.o_busy), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_flags", 64'({bus_a.o_gnt0, bus_a.o_gnt1, bus_a.o_rvalid0, bus_a.o_rvalid1,
                               bus_a.o_mem_en, bus_a.o_mem_we, bus_a.o_busy}), 64'(0));
    check("rstmid_addr", 64'(bus_a.o_mem_addr), 64'(0));
    check("rstmid_wdata", 64'(bus_a.o_mem_wdata), 64'(0));
    check("rstmid_rdata0", 64'(bus_a.o_rdata0), 64'(0));
    check("rstmid_rdata1", 64'(bus_a.o_rdata1), 64'(0));
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("rstmid_quiet_k%0d", k), 64'({bus_a.o_rvalid0, bus_a.o_mem_en, bus_a.o_busy}), 64'(0));
    end
    bus_a.i_req0 = 1'b1; bus_a.i_we0 = 1'b0; bus_a.i_addr0 = 10'h004;
    bus_a.i_req1 = 1'b1; bus_a.i_we1 = 1'b0; bus_a.i_addr1 = 10'h004;
    @(negedge clk);
    check("rstmid_tie_gnt0", 64'(bus_a.o_gnt0), 64'(1));
    check("rstmid_tie_gnt1", 64'(bus_a.o_gnt1), 64'(0));
    idle_inputs();
    repeat (6) @(negedge clk);
    check("final_idle", 64'(bus_a.o_busy), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates one single-port data RAM between two requesters: port 0 is the multicycle microprocessor data port (load/store states), and port 1 is the host/program loader. The block registers the winning command, drives the RAM for one access cycle, waits a fixed read latency, and returns read data to the requester that issued the read. It sits between the processor's memory-address register/write path and the RAM macro.

## Interface
- `AW`, 10: address width (word address).
- `DW`, 32: data width.
- `RD_LAT`, 1: RAM read latency in cycles, from the enable cycle to valid `i_mem_rdata`; legal range 1..4.

Ports:
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `i_req0` / `i_req1`  in  1: access request, level-held until granted.
- `i_we0` / `i_we1`  in  1: 1 = write, 0 = read.
- `i_addr0` / `i_addr1`  in  AW: access address.
- `i_wdata0` / `i_wdata1`  in  DW: write data.
- `o_gnt0` / `o_gnt1`  out  1: one-cycle pulse; command accepted.
- `o_rvalid0` / `o_rvalid1`  out  1: one-cycle pulse; read data valid.
- `o_rdata0` / `o_rdata1`  out  DW: read data; held until that port's next read completes.
- `o_mem_en`  out  1: RAM access strobe.
- `o_mem_we`  out  1: RAM write enable; only ever high together with `o_mem_en`.
- `o_mem_addr`  out  AW: RAM address.
- `o_mem_wdata`  out  DW: RAM write data.
- `i_mem_rdata`  in  DW: RAM read data.
- `o_busy`  out  1: high whenever the FSM is not in IDLE.

## Operation
FSM states: IDLE, ACCESS, WAIT, RESP.

- **IDLE**
  - If any `i_reqN` is high, select a winner and latch its we/addr/wdata plus a 1-bit owner tag. Next state: ACCESS.
  - With no request, remain in IDLE.
- **ACCESS** (exactly 1 cycle)
  - `o_mem_en`=1; `o_mem_we`, `o_mem_addr` and `o_mem_wdata` come from the latched command.
  - `o_gntN`=1 for the owner.
  - Write: next state is IDLE.
  - Read with `RD_LAT`=1: next state is RESP.
  - Read with `RD_LAT`>1: load the down-counter with `RD_LAT`-2 and go to WAIT.
- **WAIT**
  - Decrement the counter. Go to RESP when the counter is 0.
- **RESP**
  - Capture `i_mem_rdata` into the owner's `o_rdataN`.
  - Set the owner's `o_rvalidN` (registered), so the pulse is visible in the following IDLE cycle.
  - Next state: IDLE.
- **Arbitration**
  - A single request wins.
  - If both requests are high: the port not served last wins (round-robin). The last-served pointer updates in ACCESS.
- **Requester rule**
  - Hold req/we/addr/wdata stable until `o_gntN` is seen.
  - Deassert req at the edge that ends the gnt cycle, unless issuing back-to-back.
  - Req still high in the next IDLE cycle counts as a new request.
- **Request hold during a transaction**: a request arriving while `o_busy`=1 is not lost. It is evaluated in the next IDLE cycle.
- **Reset**
  - State returns to IDLE.
  - All outputs become 0, including `o_rdata0` and `o_rdata1`.
  - Last-served pointer resets to 1, so port 0 wins the first tie.
  - Reset during ACCESS, WAIT or RESP abandons the access: no `o_rvalid` is produced and no further `o_mem_en` is issued.

## Timing
- Request seen in IDLE at cycle I; ACCESS at I+1.
- Write: RAM written at the I+1 edge; arbiter back in IDLE at I+2. Sustained throughput is 1 write per 2 cycles.
- Read: `o_rvalidN` and the new `o_rdataN` appear at cycle I+2+`RD_LAT`. Next arbitration happens in that same cycle.
- Exactly one RAM access is in flight at any time. `o_mem_en` is never high in two consecutive cycles.
- Outputs are driven directly from registers (state, latched command), so there is no combinational path from `i_req*` to any output.

## Configuration
- `MEM_ARB_FIXED_PRIO_EN` defined: port 0 always wins ties and the last-served pointer is removed. Port 1 may starve while port 0 is continuously requesting.
- Undefined (default): round-robin arbitration as described under Operation.

## Test plan
- **Single write:** `rst` 2 cycles; port 0 writes addr 0x004, data 0xDEADBEEF → `o_gnt0` 1 cycle later, with one cycle of `o_mem_en`=1, `o_mem_we`=1 carrying 0x004/0xDEADBEEF; `o_busy` low again at I+2.
- **Read latency sweep:** preload 0x004=0xDEADBEEF; port 1 reads 0x004 with `RD_LAT`=1 and with `RD_LAT`=3 → `o_rvalid1` at I+3 and at I+5 respectively, `o_rdata1`=0xDEADBEEF, `o_rvalid0` never high.
- **Contention:** both ports request reads continuously for 4 transactions → grants alternate 0,1,0,1. With `MEM_ARB_FIXED_PRIO_EN` defined → grants are 0,0,0,0.
- **Late request:** port 1 raises req during port 0's WAIT → port 1 is granted in the ACCESS cycle that directly follows port 0's rvalid/IDLE cycle, and port 1's request is not dropped.
- **Reset mid-read:** `RD_LAT`=3, assert `rst` in WAIT → no `o_rvalid0`, all outputs 0 the next cycle, and the first tie after reset goes to port 0.
